// File: rtl/ts_pkt_buf_if.sv
// Stream and statistics bundle between the TS packet buffer and its neighbours.
interface ts_pkt_buf_if #(
    parameter int unsigned BUF_AW = 8
) ();
    logic [31:0]     ts_data;
    logic            ts_valid;
    logic            ts_start;
    logic            ts_end;
    logic [31:0]     out_data;
    logic            out_valid;
    logic            out_start;
    logic            out_end;
    logic            out_ready;
    logic [BUF_AW:0] buf_pkts;
    logic [15:0]     cnt_ok;
    logic [15:0]     cnt_drop;
    logic [15:0]     cnt_seq_err;

    modport master (
        output ts_data, ts_valid, ts_start, ts_end, out_ready,
        input  out_data, out_valid, out_start, out_end, buf_pkts,
               cnt_ok, cnt_drop, cnt_seq_err
    );

    modport slave (
        input  ts_data, ts_valid, ts_start, ts_end, out_ready,
        output out_data, out_valid, out_start, out_end, buf_pkts,
               cnt_ok, cnt_drop, cnt_seq_err
    );
endinterface

// File: rtl/ts_pkt_buf.sv
// Validating packet buffer: commits well-formed TS packets into a word RAM and
// replays them on a valid/ready stream with drop and sequence statistics.
module ts_pkt_buf #(
    parameter int unsigned PKT_WORDS = 48,
    parameter int unsigned BUF_AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    ts_pkt_buf_if.slave bus
);
    localparam int unsigned DEPTH = 1 << BUF_AW;
    localparam int unsigned PW    = BUF_AW + 1;
    localparam int unsigned CW    = $clog2(PKT_WORDS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [31:0]   mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_tmp_q, wr_tmp_d, wr_cmt_q, wr_cmt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, f_ptr_q, f_ptr_d;
    logic [PW-1:0] buf_pkts_q, buf_pkts_d;
    logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic          bad_q, bad_d;
    logic [7:0]    pnum_q, pnum_d, seq_ref_q, seq_ref_d;
    logic          seq_vld_q, seq_vld_d;
    logic [15:0]   cnt_ok_q, cnt_ok_d, cnt_drop_q, cnt_drop_d, cnt_seq_q, cnt_seq_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d, out_start_q, out_start_d, out_end_q, out_end_d;

    logic              we;
    logic [BUF_AW-1:0] waddr;
    logic [1:0]        drop_inc;
    logic              commit;
    logic [PW-1:0]     used;
    logic              space_ok;
    logic              hs;
    logic              load;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
        logic [16:0] s;
        s = 17'(a) + 17'(n);
        return (s > 17'h0FFFF) ? 16'hFFFF : s[15:0];
    endfunction

    // Space is reserved for a whole packet up front so a receive never overruns unread data.
    assign used     = wr_cmt_q - rd_ptr_q;
    assign space_ok = (32'(used) + PKT_WORDS) <= DEPTH;
    assign hs       = out_valid_q & bus.out_ready;
    assign load     = (f_ptr_q != wr_cmt_q) & (~out_valid_q | bus.out_ready);

    always_comb begin
        state_d     = state_q;
        wr_tmp_d    = wr_tmp_q;
        wr_cmt_d    = wr_cmt_q;
        wcnt_d      = wcnt_q;
        bad_d       = bad_q;
        pnum_d      = pnum_q;
        seq_ref_d   = seq_ref_q;
        seq_vld_d   = seq_vld_q;
        cnt_ok_d    = cnt_ok_q;
        cnt_seq_d   = cnt_seq_q;
        drop_inc    = 2'd0;
        commit      = 1'b0;
        we          = 1'b0;
        waddr       = wr_tmp_q[BUF_AW-1:0];

        if (bus.ts_valid) begin
            if (bus.ts_start) begin
                // A start always rewinds to the last commit point, from any state.
                if (state_q == S_RECV) drop_inc = drop_inc + 2'd1;
                if (space_ok) begin
                    we       = 1'b1;
                    waddr    = wr_cmt_q[BUF_AW-1:0];
                    wr_tmp_d = wr_cmt_q + PW'(1);
                    wcnt_d   = CW'(1);
                    bad_d    = (bus.ts_data[31:4] != 28'd0);
                    state_d  = S_RECV;
                    if (bus.ts_end) begin
                        drop_inc = drop_inc + 2'd1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = S_DROP;
                end
            end else if (state_q == S_RECV) begin
                we       = 1'b1;
                wr_tmp_d = wr_tmp_q + PW'(1);
                wcnt_d   = wcnt_q + CW'(1);
                if (wcnt_q == CW'(1)) begin
                    if (bus.ts_data[31:24] != 8'h47) bad_d = 1'b1;
                    pnum_d = bus.ts_data[23:16];
                end
                if (bus.ts_end) begin
                    state_d = S_IDLE;
                    if ((32'(wcnt_q) + 32'd1 == PKT_WORDS) && !bad_d) begin
                        commit    = 1'b1;
                        wr_cmt_d  = wr_tmp_q + PW'(1);
                        cnt_ok_d  = sat_add(cnt_ok_q, 2'd1);
                        seq_ref_d = pnum_d;
                        seq_vld_d = 1'b1;
                        if (seq_vld_q && (pnum_d != seq_ref_q + 8'd1))
                            cnt_seq_d = sat_add(cnt_seq_q, 2'd1);
                    end else begin
                        drop_inc = drop_inc + 2'd1;
                    end
                end else if (32'(wcnt_q) + 32'd1 == PKT_WORDS) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = S_DROP;
                end
            end else if ((state_q == S_DROP) && bus.ts_end) begin
                state_d = S_IDLE;
            end
        end

        cnt_drop_d = sat_add(cnt_drop_q, drop_inc);

        // Output register refills from the fetch pointer; rd_ptr trails it by the held word.
        rd_ptr_d    = hs ? rd_ptr_q + PW'(1) : rd_ptr_q;
        f_ptr_d     = f_ptr_q;
        rcnt_d      = rcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_start_d = out_start_q;
        out_end_d   = out_end_q;
        if (load) begin
            out_data_d  = mem[f_ptr_q[BUF_AW-1:0]];
            out_valid_d = 1'b1;
            out_start_d = (rcnt_q == CW'(0));
            out_end_d   = (rcnt_q == CW'(PKT_WORDS - 1));
            f_ptr_d     = f_ptr_q + PW'(1);
            rcnt_d      = (rcnt_q == CW'(PKT_WORDS - 1)) ? CW'(0) : rcnt_q + CW'(1);
        end else if (hs) begin
            out_valid_d = 1'b0;
            out_start_d = 1'b0;
            out_end_d   = 1'b0;
        end

        buf_pkts_d = buf_pkts_q + PW'(commit) - PW'(hs & out_end_q);
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= bus.ts_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_tmp_q    <= '0;
            wr_cmt_q    <= '0;
            rd_ptr_q    <= '0;
            f_ptr_q     <= '0;
            buf_pkts_q  <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            bad_q       <= 1'b0;
            pnum_q      <= '0;
            seq_ref_q   <= '0;
            seq_vld_q   <= 1'b0;
            cnt_ok_q    <= '0;
            cnt_drop_q  <= '0;
            cnt_seq_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_end_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_tmp_q    <= wr_tmp_d;
            wr_cmt_q    <= wr_cmt_d;
            rd_ptr_q    <= rd_ptr_d;
            f_ptr_q     <= f_ptr_d;
            buf_pkts_q  <= buf_pkts_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            bad_q       <= bad_d;
            pnum_q      <= pnum_d;
            seq_ref_q   <= seq_ref_d;
            seq_vld_q   <= seq_vld_d;
            cnt_ok_q    <= cnt_ok_d;
            cnt_drop_q  <= cnt_drop_d;
            cnt_seq_q   <= cnt_seq_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_start_q <= out_start_d;
            out_end_q   <= out_end_d;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_start   = out_start_q;
    assign bus.out_end     = out_end_q;
    assign bus.buf_pkts    = buf_pkts_q;
    assign bus.cnt_ok      = cnt_ok_q;
    assign bus.cnt_drop    = cnt_drop_q;
    assign bus.cnt_seq_err = cnt_seq_q;
endmodule

// File: tb/tb_ts_pkt_buf.sv
// Directed bench for ts_pkt_buf: framing checks, buffer full, restart,
// sequence tracking, reset and randomised backpressure.
module tb_ts_pkt_buf;
    localparam int unsigned PKT_WORDS = 48;
    localparam int unsigned BUF_AW    = 8;

    logic clk = 1'b0;
    logic rst_n;

    ts_pkt_buf_if #(.BUF_AW(BUF_AW)) b ();

    ts_pkt_buf #(.PKT_WORDS(PKT_WORDS), .BUF_AW(BUF_AW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b)
    );

    always #5 clk = ~clk;

    int          checks     = 0;
    int          errors     = 0;
    int          stall_viol = 0;
    logic        rand_rdy   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_w     = '0;
    logic [33:0] obs_q[$];
    logic [33:0] exp_q[$];

    // Record accepted words and flag any change of a stalled word.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!b.out_valid || ({b.out_start, b.out_end, b.out_data} !== prev_w)))
                stall_viol++;
            if (b.out_valid && b.out_ready)
                obs_q.push_back({b.out_start, b.out_end, b.out_data});
            prev_stall = b.out_valid && !b.out_ready;
            prev_w     = {b.out_start, b.out_end, b.out_data};
        end
    end

    function automatic logic [31:0] pw(input logic [3:0] ch, input logic [7:0] num,
                                       input int k, input logic [7:0] sync);
        if (k == 1) return {28'd0, ch};
        else if (k == 2) return {sync, num, 16'h0102};
        else return {8'hC3, num, 8'(k), 4'h0, ch};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) b.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_pkt(input logic [3:0] ch, input logic [7:0] num, input int n,
                            input logic [7:0] sync, input logic with_end);
        for (int k = 1; k <= n; k++) begin
            b.ts_data  = pw(ch, num, k, sync);
            b.ts_valid = 1'b1;
            b.ts_start = (k == 1);
            b.ts_end   = with_end && (k == n);
            tick();
        end
        b.ts_valid = 1'b0;
        b.ts_start = 1'b0;
        b.ts_end   = 1'b0;
    endtask

    task automatic expect_pkt(input logic [3:0] ch, input logic [7:0] num);
        for (int k = 1; k <= int'(PKT_WORDS); k++)
            exp_q.push_back({(k == 1), (k == int'(PKT_WORDS)), pw(ch, num, k, 8'h47)});
    endtask

    task automatic good_pkt(input logic [3:0] ch, input logic [7:0] num);
        send_pkt(ch, num, PKT_WORDS, 8'h47, 1'b1);
        expect_pkt(ch, num);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((b.buf_pkts != '0 || b.out_valid) && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, 64'(b.buf_pkts != '0 || b.out_valid), 64'd0);
    endtask

    task automatic check_out(input string tag);
        chk($sformatf("%s_len", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        b.ts_data  = '0;
        b.ts_valid = 1'b0;
        b.ts_start = 1'b0;
        b.ts_end   = 1'b0;
        b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(b.out_valid), 64'd0);
        chk("rst_data", 64'(b.out_data), 64'd0);
        chk("rst_buf_pkts", 64'(b.buf_pkts), 64'd0);
        chk("rst_cnt_ok", 64'(b.cnt_ok), 64'd0);
        chk("rst_cnt_drop", 64'(b.cnt_drop), 64'd0);
        chk("rst_cnt_seq", 64'(b.cnt_seq_err), 64'd0);
        rst_n = 1'b1;
        tick();

        // Continuous stream with commit-to-output latency.
        good_pkt(4'd5, 8'd1);
        chk("lat_pre_valid", 64'(b.out_valid), 64'd0);
        chk("lat_cnt_ok", 64'(b.cnt_ok), 64'd1);
        chk("lat_buf_pkts", 64'(b.buf_pkts), 64'd1);
        tick();
        chk("lat_valid", 64'(b.out_valid), 64'd1);
        chk("lat_start", 64'(b.out_start), 64'd1);
        chk("lat_data", 64'(b.out_data), 64'h5);
        good_pkt(4'd6, 8'd2);
        good_pkt(4'd7, 8'd3);
        wait_drain("stream_drain");
        check_out("stream");
        chk("stream_cnt_ok", 64'(b.cnt_ok), 64'd3);
        chk("stream_cnt_drop", 64'(b.cnt_drop), 64'd0);
        chk("stream_cnt_seq", 64'(b.cnt_seq_err), 64'd0);

        // Bad sync byte, short and long packets.
        good_pkt(4'd8, 8'd4);
        send_pkt(4'd1, 8'h01, PKT_WORDS, 8'h48, 1'b1);
        chk("badsync_drop", 64'(b.cnt_drop), 64'd1);
        good_pkt(4'd9, 8'd5);
        send_pkt(4'd9, 8'd6, PKT_WORDS - 1, 8'h47, 1'b1);
        chk("short_drop", 64'(b.cnt_drop), 64'd2);
        send_pkt(4'd9, 8'd6, PKT_WORDS + 1, 8'h47, 1'b1);
        chk("long_drop", 64'(b.cnt_drop), 64'd3);
        good_pkt(4'd10, 8'd6);
        wait_drain("bad_drain");
        check_out("bad");
        chk("bad_cnt_ok", 64'(b.cnt_ok), 64'd6);
        chk("bad_cnt_seq", 64'(b.cnt_seq_err), 64'd0);

        // Buffer full with output stalled: five fit, sixth dropped.
        b.out_ready = 1'b0;
        good_pkt(4'd11, 8'd7);
        good_pkt(4'd12, 8'd8);
        good_pkt(4'd13, 8'd9);
        good_pkt(4'd14, 8'd10);
        good_pkt(4'd15, 8'd11);
        send_pkt(4'd1, 8'd12, PKT_WORDS, 8'h47, 1'b1);
        chk("full_buf_pkts", 64'(b.buf_pkts), 64'd5);
        chk("full_cnt_drop", 64'(b.cnt_drop), 64'd4);
        chk("full_cnt_ok", 64'(b.cnt_ok), 64'd11);
        chk("full_hold_valid", 64'(b.out_valid), 64'd1);
        chk("full_hold_start", 64'(b.out_start), 64'd1);
        chk("full_hold_data", 64'(b.out_data), 64'hB);
        repeat (4) tick();
        b.out_ready = 1'b1;
        wait_drain("full_drain");
        check_out("full");
        chk("full_buf_empty", 64'(b.buf_pkts), 64'd0);

        // Restart: a new start at word 20 aborts the partial packet.
        send_pkt(4'd3, 8'd12, 19, 8'h47, 1'b0);
        good_pkt(4'd3, 8'd12);
        chk("restart_drop", 64'(b.cnt_drop), 64'd5);
        chk("restart_ok", 64'(b.cnt_ok), 64'd12);

        // Sequence gap and 0xFF -> 0x00 wrap.
        good_pkt(4'd4, 8'd13);
        good_pkt(4'd4, 8'd14);
        good_pkt(4'd4, 8'd16);
        chk("gap_seq", 64'(b.cnt_seq_err), 64'd1);
        chk("gap_ok", 64'(b.cnt_ok), 64'd15);
        good_pkt(4'd2, 8'hFF);
        chk("jump_seq", 64'(b.cnt_seq_err), 64'd2);
        good_pkt(4'd2, 8'h00);
        chk("wrap_seq", 64'(b.cnt_seq_err), 64'd2);
        chk("wrap_ok", 64'(b.cnt_ok), 64'd17);
        wait_drain("seq_drain");
        check_out("seq");

        // Commit lands on the same edge as the previous packet's out_end handshake.
        good_pkt(4'd6, 8'd1);
        tick();
        good_pkt(4'd7, 8'd2);
        chk("same_edge_buf_pkts", 64'(b.buf_pkts), 64'd1);
        chk("same_edge_ok", 64'(b.cnt_ok), 64'd19);
        wait_drain("same_drain");
        check_out("same");

        // Random backpressure.
        rand_rdy = 1'b1;
        good_pkt(4'd1, 8'd3);
        good_pkt(4'd2, 8'd4);
        good_pkt(4'd3, 8'd5);
        wait_drain("rand_drain");
        rand_rdy    = 1'b0;
        b.out_ready = 1'b1;
        check_out("rand");
        chk("rand_stall_stable", 64'(stall_viol), 64'd0);
        chk("rand_ok", 64'(b.cnt_ok), 64'd22);
        chk("rand_seq", 64'(b.cnt_seq_err), 64'd2);

        // Reset mid-stream discards committed and partial data.
        b.out_ready = 1'b0;
        send_pkt(4'd1, 8'd6, PKT_WORDS, 8'h47, 1'b1);
        send_pkt(4'd1, 8'd7, 10, 8'h47, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 64'(b.out_valid), 64'd0);
        chk("mid_rst_data", 64'(b.out_data), 64'd0);
        chk("mid_rst_start", 64'(b.out_start), 64'd0);
        chk("mid_rst_buf_pkts", 64'(b.buf_pkts), 64'd0);
        chk("mid_rst_cnt_ok", 64'(b.cnt_ok), 64'd0);
        chk("mid_rst_cnt_drop", 64'(b.cnt_drop), 64'd0);
        chk("mid_rst_cnt_seq", 64'(b.cnt_seq_err), 64'd0);
        obs_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        b.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b.ts_data  = 32'hDEAD_0000 + 32'(k);
            b.ts_valid = 1'b1;
            b.ts_start = 1'b0;
            b.ts_end   = (k == 4);
            tick();
        end
        b.ts_valid = 1'b0;
        b.ts_end   = 1'b0;
        good_pkt(4'd2, 8'h30);
        chk("resume_ok", 64'(b.cnt_ok), 64'd1);
        chk("resume_drop", 64'(b.cnt_drop), 64'd0);
        chk("resume_seq", 64'(b.cnt_seq_err), 64'd0);
        chk("resume_buf_pkts", 64'(b.buf_pkts), 64'd1);
        wait_drain("resume_drain");
        check_out("resume");
        chk("final_stall_stable", 64'(stall_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
